des_region_sequencer: RTL and testbench

Host-side initiator for the DES brute-force core's command port. Sweeps a contiguous range of 32-bit region indices and drives the command handshake for each region: load region, then start or test mode, then collect results, then restart. Captures counter/ciphertext results into a valid/ready output stream. Sits between the CPU register file and `des_block_wrapper`, replacing per-region software polling.

---
 rtl/des_region_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_des_region_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_region_sequencer.sv
// des_region_sequencer
//   Host-side initiator for the DES brute-force core's command port. It sweeps an inclusive,
//   wrapping range of 32-bit region indices. For each region it loads the region, starts a
//   search or a test run, collects the results into a valid/ready stream, and then restarts
//   the core.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, sampled only while idle
//   test_mode           0 = search sweep, 1 = test sweep (sampled with start)
//   region_first/last   inclusive region range (sampled with start)
//   test_count          results per region in a test sweep, 0 treated as 1 (sampled with start)
//   cmd, cmd_valid      command to the wrapper (0 READ_REGION, 1 START, 2 TEST_MODE, 3 RESTART)
//   region              region operand, held stable while cmd_valid is high
//   advance_test_cmd    two-cycle request for the next test result
//   cmd_read            wrapper has consumed the command
//   done                wrapper search finished (level)
//   test_res_ready      wrapper test result available (level)
//   counter, ciphertext wrapper result registers
//   res_*               result stream (valid/ready) with region, index, counter, ciphertext, last
//   busy                sweep in progress
//   sweep_done          one-cycle pulse after the final RESTART completes
module des_region_sequencer #(
   parameter int unsigned CMD_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             test_mode,
   input  logic [31:0]      region_first,
   input  logic [31:0]      region_last,
   input  logic [15:0]      test_count,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_valid,
   output logic [31:0]      region,
   output logic             advance_test_cmd,
   input  logic             cmd_read,
   input  logic             done,
   input  logic             test_res_ready,
   input  logic [63:0]      counter,
   input  logic [63:0]      ciphertext,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_region,
   output logic [15:0]      res_index,
   output logic [63:0]      res_counter,
   output logic [63:0]      res_ciphertext,
   output logic             res_last,
   output logic             busy,
   output logic             sweep_done
);

   localparam logic [CMD_W-1:0] CmdReadRegion = CMD_W'(0);
   localparam logic [CMD_W-1:0] CmdStart      = CMD_W'(1);
   localparam logic [CMD_W-1:0] CmdTestMode   = CMD_W'(2);
   localparam logic [CMD_W-1:0] CmdRestart    = CMD_W'(3);

   typedef enum logic [3:0] {
      StIdle,
      StIssue,     // assert the pending command on the next edge
      StCmdReq,    // cmd_valid high, waiting for cmd_read = 1
      StCmdRel,    // cmd_valid low, waiting for cmd_read = 0
      StWaitDone,
      StWaitTest,
      StCapture,   // wrapper result registers settle one cycle after the event
      StPresent,
      StPush,
      StAdvance
   } state_e;

   state_e           state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [CMD_W-1:0] pend_q, pend_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [31:0]      region_q, region_d;
   logic [31:0]      last_q, last_d;
   logic             mode_q, mode_d;
   logic [15:0]      tcount_q, tcount_d;
   logic [15:0]      idx_q, idx_d;
   logic             seen_low_q, seen_low_d;
   logic             adv_q, adv_d;
   logic             adv_cnt_q, adv_cnt_d;
   logic             res_valid_q, res_valid_d;
   logic [31:0]      res_region_q, res_region_d;
   logic [15:0]      res_index_q, res_index_d;
   logic [63:0]      res_counter_q, res_counter_d;
   logic [63:0]      res_ct_q, res_ct_d;
   logic             res_last_q, res_last_d;
   logic             busy_q, busy_d;
   logic             sweep_done_q, sweep_done_d;

   // A search region yields one result; a test region yields tcount_q results.
   logic idx_last;
   assign idx_last = ~mode_q | (idx_q == (tcount_q - 16'd1));

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      pend_d       = pend_q;
      cmd_valid_d  = cmd_valid_q;
      region_d     = region_q;
      last_d       = last_q;
      mode_d       = mode_q;
      tcount_d     = tcount_q;
      idx_d        = idx_q;
      seen_low_d   = seen_low_q;
      adv_d        = adv_q;
      adv_cnt_d    = adv_cnt_q;
      res_valid_d  = res_valid_q;
      res_region_d = res_region_q;
      res_index_d  = res_index_q;
      res_counter_d = res_counter_q;
      res_ct_d     = res_ct_q;
      res_last_d   = res_last_q;
      busy_d       = busy_q;
      sweep_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d   = test_mode;
               region_d = region_first;
               last_d   = region_last;
               tcount_d = (test_count == 16'd0) ? 16'd1 : test_count;
               idx_d    = 16'd0;
               pend_d   = CmdReadRegion;
               busy_d   = 1'b1;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            cmd_d       = pend_q;
            cmd_valid_d = 1'b1;
            state_d     = StCmdReq;
         end
         StCmdReq: begin
            if (cmd_read) begin
               cmd_valid_d = 1'b0;
               state_d     = StCmdRel;
            end
         end
         StCmdRel: begin
            if (!cmd_read) begin
               if (cmd_q == CmdReadRegion) begin
                  pend_d  = mode_q ? CmdTestMode : CmdStart;
                  state_d = StIssue;
               end else if (cmd_q == CmdStart) begin
                  state_d = StWaitDone;
               end else if (cmd_q == CmdTestMode) begin
                  // The first test result needs only a high level, not an edge.
                  seen_low_d = 1'b1;
                  state_d    = StWaitTest;
               end else if (region_q == last_q) begin
                  sweep_done_d = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = StIdle;
               end else begin
                  region_d = region_q + 32'd1;
                  idx_d    = 16'd0;
                  pend_d   = CmdReadRegion;
                  state_d  = StIssue;
               end
            end
         end
         StWaitDone: begin
            if (done) state_d = StCapture;
         end
         StWaitTest: begin
            if (test_res_ready && seen_low_q) begin
               state_d = StCapture;
            end else if (!test_res_ready) begin
               seen_low_d = 1'b1;
            end
         end
         StCapture: begin
            res_region_d  = region_q;
            res_index_d   = idx_q;
            res_counter_d = counter;
            res_ct_d      = ciphertext;
            res_last_d    = (region_q == last_q) && idx_last;
            state_d       = StPresent;
         end
         StPresent: begin
            res_valid_d = 1'b1;
            state_d     = StPush;
         end
         StPush: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (idx_last) begin
                  cmd_d       = CmdRestart;
                  cmd_valid_d = 1'b1;
                  state_d     = StCmdReq;
               end else begin
                  idx_d      = idx_q + 16'd1;
                  adv_d      = 1'b1;
                  adv_cnt_d  = 1'b0;
                  seen_low_d = 1'b0;
                  state_d    = StAdvance;
               end
            end
         end
         StAdvance: begin
            // The ready level may fall during the pulse; remember that for edge detection.
            if (!test_res_ready) seen_low_d = 1'b1;
            if (adv_cnt_q) begin
               adv_d   = 1'b0;
               state_d = StWaitTest;
            end else begin
               adv_cnt_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cmd_q         <= '0;
         pend_q        <= '0;
         cmd_valid_q   <= 1'b0;
         region_q      <= '0;
         last_q        <= '0;
         mode_q        <= 1'b0;
         tcount_q      <= 16'd1;
         idx_q         <= '0;
         seen_low_q    <= 1'b0;
         adv_q         <= 1'b0;
         adv_cnt_q     <= 1'b0;
         res_valid_q   <= 1'b0;
         res_region_q  <= '0;
         res_index_q   <= '0;
         res_counter_q <= '0;
         res_ct_q      <= '0;
         res_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         pend_q        <= pend_d;
         cmd_valid_q   <= cmd_valid_d;
         region_q      <= region_d;
         last_q        <= last_d;
         mode_q        <= mode_d;
         tcount_q      <= tcount_d;
         idx_q         <= idx_d;
         seen_low_q    <= seen_low_d;
         adv_q         <= adv_d;
         adv_cnt_q     <= adv_cnt_d;
         res_valid_q   <= res_valid_d;
         res_region_q  <= res_region_d;
         res_index_q   <= res_index_d;
         res_counter_q <= res_counter_d;
         res_ct_q      <= res_ct_d;
         res_last_q    <= res_last_d;
         busy_q        <= busy_d;
         sweep_done_q  <= sweep_done_d;
      end
   end

   assign cmd              = cmd_q;
   assign cmd_valid        = cmd_valid_q;
   assign region           = region_q;
   assign advance_test_cmd = adv_q;
   assign res_valid        = res_valid_q;
   assign res_region       = res_region_q;
   assign res_index        = res_index_q;
   assign res_counter      = res_counter_q;
   assign res_ciphertext   = res_ct_q;
   assign res_last         = res_last_q;
   assign busy             = busy_q;
   assign sweep_done       = sweep_done_q;

endmodule

// File: tb/tb_des_region_sequencer.sv
// Bench for des_region_sequencer: a behavioural wrapper model answers commands, expected
// commands and results are queued by the stimulus and popped by monitors.
module tb_des_region_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        test_mode = 1'b0;
   logic [31:0] region_first = '0;
   logic [31:0] region_last = '0;
   logic [15:0] test_count = '0;
   logic [31:0] cmd;
   logic        cmd_valid;
   logic [31:0] region;
   logic        advance_test_cmd;
   logic        cmd_read;
   logic        done;
   logic        test_res_ready;
   logic [63:0] counter;
   logic [63:0] ciphertext;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_region;
   logic [15:0] res_index;
   logic [63:0] res_counter;
   logic [63:0] res_ciphertext;
   logic        res_last;
   logic        busy;
   logic        sweep_done;

   always #5 clk = ~clk;

   des_region_sequencer #(.CMD_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .test_mode(test_mode),
      .region_first(region_first), .region_last(region_last), .test_count(test_count),
      .cmd(cmd), .cmd_valid(cmd_valid), .region(region), .advance_test_cmd(advance_test_cmd),
      .cmd_read(cmd_read), .done(done), .test_res_ready(test_res_ready),
      .counter(counter), .ciphertext(ciphertext), .res_valid(res_valid), .res_ready(res_ready),
      .res_region(res_region), .res_index(res_index), .res_counter(res_counter),
      .res_ciphertext(res_ciphertext), .res_last(res_last), .busy(busy),
      .sweep_done(sweep_done)
   );

   typedef struct { logic [31:0] code; logic [31:0] rgn; } cmd_t;
   typedef struct {
      logic [31:0] rgn; logic [15:0] idx; logic [63:0] cnt; logic [63:0] ct; logic last;
   } res_t;

   cmd_t exp_cmd[$];
   res_t exp_res[$];
   int   n_cmp = 0;
   int   n_err = 0;

   localparam logic [63:0] STALE = 64'hBAD0_BAD0_BAD0_BAD0;

   // Wrapper model configuration.
   int          cmd_delay = 0;
   int          done_delay = 10;
   int          tr_delay = 3;
   logic [63:0] cnt_base = '0;
   logic [63:0] ct_base = '0;
   logic        stall_en = 1'b0;

   int          adv_pulses = 0;
   int          done_pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_c(input logic [31:0] code, input logic [31:0] rgn);
      cmd_t c;
      c.code = code; c.rgn = rgn;
      exp_cmd.push_back(c);
   endtask

   task automatic exp_r(input logic [31:0] rgn, input logic [15:0] idx, input logic [63:0] cnt,
                        input logic [63:0] ct, input logic last);
      res_t r;
      r.rgn = rgn; r.idx = idx; r.cnt = cnt; r.ct = ct; r.last = last;
      exp_res.push_back(r);
   endtask

   // Wrapper model: counter/ciphertext update one cycle after done/test_res_ready rises.
   initial begin : wrapper_model
      int          wait_cnt, done_tmr, tr_tmr, adv_run, m_idx;
      logic        late_upd, rel_pend, snap_vld, stab_bad;
      logic [31:0] snap_cmd, snap_rgn, m_region;
      cmd_t        ec;
      wait_cnt = 0; done_tmr = -1; tr_tmr = -1; adv_run = 0; m_idx = 0; m_region = '0;
      late_upd = 0; rel_pend = 0; snap_vld = 0; stab_bad = 0; snap_cmd = '0; snap_rgn = '0;
      cmd_read = 0; done = 0; test_res_ready = 0; counter = '0; ciphertext = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cmd_read = 0; done = 0; test_res_ready = 0;
            done_tmr = -1; tr_tmr = -1; late_upd = 0; rel_pend = 0; snap_vld = 0; adv_run = 0;
         end else begin
            if (late_upd) begin
               counter    = cnt_base + 64'(m_region);
               ciphertext = ct_base + 64'(m_idx);
               late_upd   = 0;
            end
            if (done_tmr > 0) done_tmr--;
            else if (done_tmr == 0) begin done = 1; late_upd = 1; done_tmr = -1; end
            if (tr_tmr > 0) tr_tmr--;
            else if (tr_tmr == 0) begin test_res_ready = 1; late_upd = 1; tr_tmr = -1; end
            if (advance_test_cmd) begin
               if (adv_run == 0) begin
                  test_res_ready = 0; m_idx++; tr_tmr = tr_delay; counter = STALE;
               end
               adv_run++;
            end else if (adv_run > 0) begin
               check("adv_width", 64'(adv_run), 64'd2);
               adv_pulses++;
               adv_run = 0;
            end
            if (rel_pend) begin
               check("cmd_valid_drop", 64'(cmd_valid), 64'd0);
               cmd_read = 0; rel_pend = 0; snap_vld = 0;
            end else if (cmd_valid) begin
               if (!snap_vld) begin
                  snap_cmd = cmd; snap_rgn = region; snap_vld = 1; wait_cnt = 0; stab_bad = 0;
               end else if (cmd !== snap_cmd || region !== snap_rgn) begin
                  stab_bad = 1;
               end
               if (wait_cnt >= cmd_delay) begin
                  check("cmd_stable", 64'(stab_bad), 64'd0);
                  if (exp_cmd.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL unexpected_cmd: got %0d/%h expected none", cmd, region);
                  end else begin
                     ec = exp_cmd.pop_front();
                     check("cmd_code", 64'(cmd), 64'(ec.code));
                     check("cmd_region", 64'(region), 64'(ec.rgn));
                  end
                  case (cmd)
                     32'd0: begin m_region = region; m_idx = 0; end
                     32'd1: begin done_tmr = done_delay; counter = STALE; ciphertext = STALE; end
                     32'd2: begin tr_tmr = tr_delay; counter = STALE; ciphertext = STALE; end
                     default: begin
                        done = 0; test_res_ready = 0; done_tmr = -1; tr_tmr = -1; m_idx = 0;
                     end
                  endcase
                  cmd_read = 1; rel_pend = 1;
               end else begin
                  wait_cnt++;
               end
            end
         end
      end
   end

   // Result sink: always ready, or stall each result for 20 cycles.
   initial begin : sink
      int stall_cnt;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (!stall_en) res_ready = 1;
         else if (!res_valid) begin res_ready = 0; stall_cnt = 0; end
         else if (stall_cnt >= 20) res_ready = 1;
         else stall_cnt++;
      end
   end

   // Result monitor and sweep_done counter.
   initial begin : res_monitor
      logic         r_snap, stall_bad;
      logic [176:0] snap_pl;
      res_t         e;
      r_snap = 0; stall_bad = 0; snap_pl = '0;
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            r_snap = 0;
         end else begin
            if (sweep_done) done_pulses++;
            if (res_valid) begin
               if (!r_snap) begin
                  snap_pl = {res_region, res_index, res_counter, res_ciphertext, res_last};
                  r_snap = 1; stall_bad = 0;
               end else if ({res_region, res_index, res_counter, res_ciphertext, res_last}
                            !== snap_pl) begin
                  stall_bad = 1;
               end
               if (!res_ready && (advance_test_cmd || cmd_valid)) stall_bad = 1;
               if (res_ready) begin
                  check("res_stable", 64'(stall_bad), 64'd0);
                  if (exp_res.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL unexpected_result: got region %h expected none", res_region);
                  end else begin
                     e = exp_res.pop_front();
                     check("res_region", 64'(res_region), 64'(e.rgn));
                     check("res_index", 64'(res_index), 64'(e.idx));
                     check("res_counter", res_counter, e.cnt);
                     check("res_ciphertext", res_ciphertext, e.ct);
                     check("res_last", 64'(res_last), 64'(e.last));
                  end
                  r_snap = 0;
               end
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, 64'({cmd_valid, advance_test_cmd, res_valid, res_last, busy,
                                  sweep_done}), 64'd0);
      check({tag, "_cmd"}, 64'(cmd), 64'd0);
      check({tag, "_region"}, 64'(region), 64'd0);
      check({tag, "_res_region"}, 64'(res_region), 64'd0);
      check({tag, "_res_index"}, 64'(res_index), 64'd0);
      check({tag, "_res_counter"}, res_counter, 64'd0);
      check({tag, "_res_ct"}, res_ciphertext, 64'd0);
   endtask

   task automatic run_sweep(input logic tm, input logic [31:0] first, input logic [31:0] last,
                            input logic [15:0] tc, input int exp_adv);
      int n, p0, a0;
      p0 = done_pulses; a0 = adv_pulses;
      @(negedge clk);
      test_mode = tm; region_first = first; region_last = last; test_count = tc; start = 1;
      @(negedge clk);
      start = 0;
      #2 check("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk); #2;
      check("first_cmd_valid", 64'(cmd_valid), 64'd1);
      check("first_cmd_code", 64'(cmd), 64'd0);
      check("first_cmd_region", 64'(region), 64'(first));
      n = 0;
      while (done_pulses == p0 && n < 5000) begin @(negedge clk); #2; n++; end
      if (done_pulses == p0) begin
         n_cmp++; n_err++;
         $display("FAIL sweep_timeout: got no sweep_done expected one within 5000 cycles");
      end
      repeat (2) @(negedge clk);
      #2;
      check("sweep_done_count", 64'(done_pulses - p0), 64'd1);
      check("busy_idle", 64'(busy), 64'd0);
      check("cmds_left", 64'(exp_cmd.size()), 64'd0);
      check("results_left", 64'(exp_res.size()), 64'd0);
      check("adv_pulses", 64'(adv_pulses - a0), 64'(exp_adv));
      exp_cmd.delete();
      exp_res.delete();
   endtask

   logic [31:0] t2_rgn [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
   logic [63:0] t2_cnt [4] = '{64'h1_0000_0FFE, 64'h1_0000_0FFF, 64'h1000, 64'h1001};

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of test expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      #2 check_all_zero("reset");
      rst = 0;

      // One search region: 0x11E + 5 = 0x123.
      cnt_base = 64'h11E; ct_base = 64'hDEAD; done_delay = 10;
      exp_c(0, 5); exp_c(1, 5); exp_c(3, 5);
      exp_r(5, 0, 64'h123, 64'hDEAD, 1);
      run_sweep(0, 5, 5, 16'd0, 0);

      // Wrapping search range.
      cnt_base = 64'h1000; ct_base = 64'hBEEF; done_delay = 3;
      for (int i = 0; i < 4; i++) begin
         exp_c(0, t2_rgn[i]); exp_c(1, t2_rgn[i]); exp_c(3, t2_rgn[i]);
         exp_r(t2_rgn[i], 0, t2_cnt[i], 64'hBEEF, i == 3);
      end
      run_sweep(0, 32'hFFFF_FFFE, 32'h1, 16'd0, 0);

      // Test sweep, three results in one region.
      cnt_base = 64'h200; ct_base = 64'h5000;
      exp_c(0, 7); exp_c(2, 7); exp_c(3, 7);
      exp_r(7, 0, 64'h207, 64'h5000, 0);
      exp_r(7, 1, 64'h207, 64'h5001, 0);
      exp_r(7, 2, 64'h207, 64'h5002, 1);
      run_sweep(1, 7, 7, 16'd3, 2);

      // Test sweep with every result stalled for 20 cycles.
      stall_en = 1; res_ready = 0;
      exp_c(0, 32'h20); exp_c(2, 32'h20); exp_c(3, 32'h20);
      exp_r(32'h20, 0, 64'h220, 64'h5000, 0);
      exp_r(32'h20, 1, 64'h220, 64'h5001, 1);
      run_sweep(1, 32'h20, 32'h20, 16'd2, 1);
      stall_en = 0;

      // Slow cmd_read on every command, two search regions.
      cnt_base = 64'h11E; ct_base = 64'hDEAD; cmd_delay = 5;
      exp_c(0, 32'h42); exp_c(1, 32'h42); exp_c(3, 32'h42);
      exp_c(0, 32'h43); exp_c(1, 32'h43); exp_c(3, 32'h43);
      exp_r(32'h42, 0, 64'h160, 64'hDEAD, 0);
      exp_r(32'h43, 0, 64'h161, 64'hDEAD, 1);
      run_sweep(0, 32'h42, 32'h43, 16'd0, 0);
      cmd_delay = 0;

      // test_count = 0 behaves as one result.
      cnt_base = 64'h200; ct_base = 64'h5000;
      exp_c(0, 3); exp_c(2, 3); exp_c(3, 3);
      exp_r(3, 0, 64'h203, 64'h5000, 1);
      run_sweep(1, 3, 3, 16'd0, 0);

      // Reset while waiting for done, then a fresh sweep.
      done_delay = 1000;
      exp_c(0, 9); exp_c(1, 9);
      @(negedge clk);
      test_mode = 0; region_first = 9; region_last = 9; start = 1;
      @(negedge clk);
      start = 0;
      repeat (30) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      check("pre_reset_cmds", 64'(exp_cmd.size()), 64'd0);
      #2 rst = 1;
      #1 check_all_zero("mid_reset");
      exp_cmd.delete(); exp_res.delete();
      repeat (2) @(negedge clk);
      rst = 0;
      done_delay = 4; cnt_base = 64'h11E; ct_base = 64'hDEAD;
      exp_c(0, 9); exp_c(1, 9); exp_c(3, 9);
      exp_r(9, 0, 64'h127, 64'hDEAD, 1);
      run_sweep(0, 9, 9, 16'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
